// File: rtl/cmp_pkg.sv
// Shared constants for the iterative branch comparator: RV32I funct3 branch
// encodings, FSM state codes and the branch-condition decode.
package cmp_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Signed compares (10x) are turned into unsigned ones by flipping the MSBs.
  function automatic logic is_signed_cmp(input logic [2:0] f3);
    return f3[2:1] == 2'b10;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic lt,
                                        input logic eq);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:           t = eq;
      F3_BNE:           t = ~eq;
      F3_BLT, F3_BLTU:  t = lt;
      F3_BGE, F3_BGEU:  t = ~lt;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/digit_cmp.sv
// Combinational unsigned compare of one DIGIT-wide operand slice.
module digit_cmp #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             lt_o,
  output logic             eq_o
);

  assign lt_o = a_i < b_i;
  assign eq_o = a_i == b_i;

endmodule

// File: rtl/branch_compare_seq.sv
// Iterative MSB-first branch comparator, one DIGIT slice per cycle.
// Define CMP_EARLY_EXIT_EN to finish on the first differing slice.
//
// state | meaning
// IDLE  | waiting for start, results held
// SCAN  | comparing slice idx_q, MSB slice first
// DONE  | one-cycle done pulse, results valid
module branch_compare_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             lt_o,
  output logic             eq_o,
  output logic             taken_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
`ifdef CMP_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       f3_q, f3_d;
  logic             found_q, found_d;
  logic             lt_scan_q, lt_scan_d;
  logic             lt_q, lt_d, eq_q, eq_d, taken_q, taken_d;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic             s_lt, s_eq;
  logic             fin_lt, fin_eq;

  assign a_dig = a_q[idx_q*DIGIT +: DIGIT];
  assign b_dig = b_q[idx_q*DIGIT +: DIGIT];

  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .a_i  (a_dig),
    .b_i  (b_dig),
    .lt_o (s_lt),
    .eq_o (s_eq)
  );

  // The first differing slice decides lt; later slices never override it.
  assign fin_lt = found_q ? lt_scan_q : s_lt;
  assign fin_eq = ~found_q & s_eq;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    f3_d      = f3_q;
    found_d   = found_q;
    lt_scan_d = lt_scan_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
    taken_d   = taken_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a_d       = a_i;
          b_d       = b_i;
          if (is_signed_cmp(funct3_i)) begin
            a_d[WIDTH-1] = ~a_i[WIDTH-1];
            b_d[WIDTH-1] = ~b_i[WIDTH-1];
          end
          f3_d      = funct3_i;
          idx_d     = IDX_LAST;
          found_d   = 1'b0;
          lt_scan_d = 1'b0;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!found_q && !s_eq) begin
          found_d   = 1'b1;
          lt_scan_d = s_lt;
        end
        if (idx_q == '0 || (EARLY_EXIT && !s_eq)) begin
          lt_d    = fin_lt;
          eq_d    = fin_eq;
          taken_d = branch_taken(f3_q, fin_lt, fin_eq);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      found_q   <= 1'b0;
      lt_scan_q <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      f3_q      <= f3_d;
      found_q   <= found_d;
      lt_scan_q <= lt_scan_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      taken_q   <= taken_d;
    end
  end

  assign busy_o  = state_q != ST_IDLE;
  assign done_o  = state_q == ST_DONE;
  assign lt_o    = lt_q;
  assign eq_o    = eq_q;
  assign taken_o = taken_q;

endmodule

// File: tb/tb_branch_compare_seq.sv
// Scoreboard bench for branch_compare_seq: directed branch vectors, busy-start
// rejection and mid-scan reset; a monitor checks every done pulse.
module tb_branch_compare_seq;
  import cmp_pkg::*;

  localparam int W = 32;
  localparam int D = 8;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   funct3 = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, lt, eq, taken;

  branch_compare_seq #(.WIDTH(W), .DIGIT(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start),
    .funct3_i (funct3),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .done_o   (done),
    .lt_o     (lt),
    .eq_o     (eq),
    .taken_o  (taken)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        lt;
    logic        eq;
    logic        tk;
    int unsigned at;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // k = 1-based position (from MSB) of the first differing slice, N if equal.
  function automatic int unsigned done_cycle(input int k);
`ifdef CMP_EARLY_EXIT_EN
    return k + 1;
`else
    return N + 1;
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        e = sb.pop_front();
        check("lt", 32'(lt), 32'(e.lt));
        check("eq", 32'(eq), 32'(e.eq));
        check("taken", 32'(taken), 32'(e.tk));
        check("done_cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && sb.size() == 0) return;
    end
    check("timeout_idle", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic elt, input logic eeq, input logic etk, input int k);
    exp_t e;
    wait_idle();
    funct3 = f3; a = av; b = bv; start = 1'b1;
    e.lt = elt; e.eq = eeq; e.tk = etk; e.at = cyc + done_cycle(k);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    wait_idle();
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_lt", 32'(lt), 32'd0);
    check("rst_eq", 32'(eq), 32'd0);
    check("rst_taken", 32'(taken), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(F3_BLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1);
    run_op(F3_BLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1);
    run_op(F3_BEQ,  32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b1, N);
    run_op(F3_BGE,  32'h0000_0100, 32'h0000_0101, 1'b1, 1'b0, 1'b0, N);
    run_op(F3_BLTU, 32'h1234_0000, 32'h1235_0000, 1'b1, 1'b0, 1'b1, 2);
    run_op(F3_BGEU, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1);
    run_op(F3_BLT,  32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1);
    run_op(3'b010,  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1);
    run_op(F3_BNE,  32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b1, N);

    // Start in cycle 2 of a BNE must be ignored.
    wait_idle();
    funct3 = F3_BNE; a = 32'd5; b = 32'd5; start = 1'b1;
    e.lt = 1'b0; e.eq = 1'b1; e.tk = 1'b0; e.at = cyc + done_cycle(N);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    funct3 = F3_BLT; a = 32'd1; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);

    // Reset during SCAN discards the operation with no done pulse.
    funct3 = F3_BEQ; a = 32'd7; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_lt", 32'(lt), 32'd0);
    check("mid_rst_eq", 32'(eq), 32'd0);
    check("mid_rst_taken", 32'(taken), 32'd0);
    repeat (8) @(negedge clk);
    run_op(F3_BEQ, 32'd7, 32'd7, 1'b0, 1'b1, 1'b1, N);

    repeat (4) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
